data_inf_axis_framer: RTL and testbench
=======================================

# data_inf_axis_framer

Converts an unframed valid/ready word stream (`data_inf_c` style) into framed AXI-Stream packets for the `axi_stream_inf` consumer stage directly downstream. It sets `tlast` after every FRAME_LEN beats, or early when the input stays idle for TIMEOUT cycles in mid-frame. It flags start-of-frame on `tuser`, sustains one beat per cycle, and counts completed frames.

## Interface
- DSIZE, 8, data width of input and output stream.
- FRAME_LEN, 16, beats per full frame; ≥1.
- TIMEOUT, 64, idle cycles before a partial frame is closed; 0 disables the timeout.
- clock  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DSIZE  upstream word.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  accept; handshake = in_valid & in_ready.
- m_tdata  output  DSIZE  AXI-Stream data.
- m_tvalid  output  1  AXI-Stream valid.
- m_tready  input  1  AXI-Stream ready.
- m_tlast  output  1  last beat of frame.
- m_tuser  output  1  first beat of frame (SOF).
- frame_cnt  output  16  completed frames; increments on `m_tvalid & m_tready & m_tlast`; wraps 0xFFFF→0.
- flush_pulse  output  1  one-cycle pulse when a timeout closes a partial frame.

## Operation
- The block has two registered stages:
  - Hold register H: `h_valid`, `h_data`, `h_idx` (position 1..FRAME_LEN, width `$clog2(FRAME_LEN+1)`), `h_final`.
  - Output register O: drives all `m_*` outputs.
- `o_free = !m_tvalid | m_tready`.
- `in_ready = !rst & (!h_valid | o_free)`. This is combinational.
- Accepted word loads H:
  - `h_idx` = 1 if H was empty-after-final or at frame start; otherwise previous idx+1.
  - `h_final` = (`h_idx == FRAME_LEN`).
- H→O move occurs when `h_valid & o_free & (accept | h_final)`:
  - `m_tlast <= h_final`.
  - `m_tuser <= (h_idx == 1)`.
  - `m_tdata <= h_data`.
- If H moves without a simultaneous accept, `h_valid` clears.
- The last beat of a frame is withheld in H until its status is known. A non-final beat leaves H only when the next word is accepted.
- Idle counter `idle_cnt`:
  - Clears on any accept or when H is empty.
  - Increments each cycle while `h_valid & !h_final & !accept`.
  - On reaching TIMEOUT: `h_final <= 1`, and `flush_pulse` asserts for that one cycle.
- An accept in the same cycle the counter would reach TIMEOUT wins. No flush occurs, the counter clears, and normal indexing continues.
- After a final beat is moved, the next accepted word starts a new frame (idx=1).
- Output stage follows AXI-Stream rules:
  - Once `m_tvalid` is high, `m_tdata`, `m_tlast` and `m_tuser` stay stable until `m_tready`.
  - `m_tvalid` never drops without a handshake.
- FRAME_LEN=1: every beat is final, so `tlast = tuser = 1` on every beat.

## Timing
- Reset values: `m_tvalid`, `m_tlast`, `m_tuser`, `m_tdata`, `frame_cnt`, `flush_pulse` = 0. `in_ready` = 0 while `rst` is high. H is empty and `idle_cnt` = 0 after reset.
- Reset mid-frame discards the contents of H and O with no output flush. The first word after reset carries `tuser = 1`.
- Final-beat latency: accept at cycle t → H at t+1 → `m_tvalid` at t+2 (O free).
- Non-final beat: appears on `m_*` the cycle after the following word's accept.
- Timeout: last word accepted at t; `flush_pulse` at t+TIMEOUT; `m_tvalid` with `tlast` at t+TIMEOUT+1 (O free).
- Throughput: with `in_valid = m_tready = 1`, one beat per cycle sustained across frame boundaries, with no bubbles.
- Backpressure: after `m_tready` goes low, at most 2 further words are absorbed (H, then O). `in_ready` then drops combinationally. No data loss or reordering.
- `frame_cnt` updates the cycle after the `tlast` handshake.

## Test plan
- FRAME_LEN=4, 8 contiguous words 0x10–0x17, `m_tready = 1`: output is 0x10–0x17 in order, one per cycle after a 2-cycle fill. `tuser` on 0x10 and 0x14. `tlast` on 0x13 and 0x17. `frame_cnt` = 2.
- TIMEOUT=8, FRAME_LEN=16, send 0xA0–0xA2 then idle: `flush_pulse` fires 8 cycles after 0xA2's accept. 0xA2 is output with `tlast = 1` one cycle later. The next word 0xB0 carries `tuser = 1`.
- Hold `m_tready` low for 10 cycles mid-stream: `in_ready` drops after exactly 2 extra accepts. Data stays stable on `m_*`. On release, the sequence is complete and in order.
- Accept arrives in the same cycle `idle_cnt` would reach TIMEOUT: no `flush_pulse`. The frame continues and `h_idx` increments normally.
- Assert `rst` for 1 cycle at frame position 3: all outputs are 0 the next cycle. The following word 0x55 is output with `tuser = 1`, and the frame closes after FRAME_LEN new beats.
- FRAME_LEN=1, 5 words: every output beat has `tuser = tlast = 1`. `frame_cnt` = 5. `frame_cnt` wraps from 0xFFFF to 0 after preloading via 65536 frames (long test).

Source files
------------

// File: rtl/data_inf_axis_framer.sv
// Frames an unframed valid/ready word stream into AXI-Stream packets: tlast every
// FRAME_LEN beats or after TIMEOUT idle cycles mid-frame, tuser on the first beat.
module data_inf_axis_framer #(
  parameter int DSIZE     = 8,
  parameter int FRAME_LEN = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [DSIZE-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DSIZE-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             m_tuser,
  output logic [15:0]      frame_cnt,
  output logic             flush_pulse
);

  localparam int IDX_W = $clog2(FRAME_LEN + 1);
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Hold stage
  logic             h_valid_q, h_valid_d;
  logic [DSIZE-1:0] h_data_q,  h_data_d;
  logic [IDX_W-1:0] h_idx_q,   h_idx_d;
  logic             h_final_q, h_final_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  // Output stage
  logic             o_valid_q, o_valid_d;
  logic [DSIZE-1:0] o_data_q,  o_data_d;
  logic             o_last_q,  o_last_d;
  logic             o_user_q,  o_user_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             o_free;
  logic             accept;
  logic             timeout_hit;
  logic             close_frame;
  logic             move;
  logic [IDX_W-1:0] acc_idx;

  assign o_free   = !o_valid_q | m_tready;
  assign in_ready = !rst & (!h_valid_q | o_free);
  assign accept   = in_valid & in_ready;

  // idle_cnt_q holds completed idle cycles, so the limit is hit in the TIMEOUT-th
  // idle cycle and the withheld beat can leave H in that same cycle.
  assign timeout_hit = TO_EN & !rst & h_valid_q & !h_final_q & !accept &
                       (idle_cnt_q == CNT_LIMIT);
  assign close_frame = h_final_q | timeout_hit;
  assign move        = h_valid_q & o_free & (accept | close_frame);

  // H empty only ever follows a final beat or reset, so it always means frame start.
  assign acc_idx = (!h_valid_q | h_final_q) ? IDX_FIRST : h_idx_q + IDX_W'(1);

  always_comb begin
    h_valid_d   = h_valid_q;
    h_data_d    = h_data_q;
    h_idx_d     = h_idx_q;
    h_final_d   = h_final_q;
    idle_cnt_d  = idle_cnt_q;
    o_valid_d   = o_valid_q;
    o_data_d    = o_data_q;
    o_last_d    = o_last_q;
    o_user_d    = o_user_q;
    frame_cnt_d = frame_cnt_q;

    if (accept) begin
      h_valid_d = 1'b1;
      h_data_d  = in_data;
      h_idx_d   = acc_idx;
      h_final_d = (acc_idx == IDX_LAST);
    end else if (move) begin
      h_valid_d = 1'b0;
      h_final_d = 1'b0;
    end else if (timeout_hit) begin
      h_final_d = 1'b1;
    end

    if (!TO_EN || accept || !h_valid_q || close_frame) begin
      idle_cnt_d = '0;
    end else begin
      idle_cnt_d = idle_cnt_q + CNT_W'(1);
    end

    if (move) begin
      o_valid_d = 1'b1;
      o_data_d  = h_data_q;
      o_last_d  = close_frame;
      o_user_d  = (h_idx_q == IDX_FIRST);
    end else if (m_tready) begin
      o_valid_d = 1'b0;
    end

    if (o_valid_q && m_tready && o_last_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      h_valid_q   <= 1'b0;
      h_data_q    <= '0;
      h_idx_q     <= '0;
      h_final_q   <= 1'b0;
      idle_cnt_q  <= '0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
      o_last_q    <= 1'b0;
      o_user_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      h_valid_q   <= h_valid_d;
      h_data_q    <= h_data_d;
      h_idx_q     <= h_idx_d;
      h_final_q   <= h_final_d;
      idle_cnt_q  <= idle_cnt_d;
      o_valid_q   <= o_valid_d;
      o_data_q    <= o_data_d;
      o_last_q    <= o_last_d;
      o_user_q    <= o_user_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign m_tvalid    = o_valid_q;
  assign m_tdata     = o_data_q;
  assign m_tlast     = o_last_q;
  assign m_tuser     = o_user_q;
  assign frame_cnt   = frame_cnt_q;
  assign flush_pulse = timeout_hit;

endmodule

// File: tb/tb_data_inf_axis_framer.sv
// Bench for data_inf_axis_framer: two instances (FRAME_LEN=4/TIMEOUT=8 and
// FRAME_LEN=1/no timeout) share one input stream; a timestamp-based frame model predicts output.
module tb_data_inf_axis_framer;

  localparam int FL_A = 4;
  localparam int TO_A = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        m_tready;

  logic        a_in_ready, a_tvalid, a_tlast, a_tuser, a_flush;
  logic [7:0]  a_tdata;
  logic [15:0] a_fc;
  logic        b_in_ready, b_tvalid, b_tlast, b_tuser, b_flush;
  logic [7:0]  b_tdata;
  logic [15:0] b_fc;

  always #5 clk = ~clk;

  data_inf_axis_framer #(.DSIZE(8), .FRAME_LEN(FL_A), .TIMEOUT(TO_A)) dut_a (
    .clock(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
    .m_tdata(a_tdata), .m_tvalid(a_tvalid), .m_tready(m_tready), .m_tlast(a_tlast),
    .m_tuser(a_tuser), .frame_cnt(a_fc), .flush_pulse(a_flush)
  );

  data_inf_axis_framer #(.DSIZE(8), .FRAME_LEN(1), .TIMEOUT(0)) dut_b (
    .clock(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
    .m_tdata(b_tdata), .m_tvalid(b_tvalid), .m_tready(m_tready), .m_tlast(b_tlast),
    .m_tuser(b_tuser), .frame_cnt(b_fc), .flush_pulse(b_flush)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       user;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  // Model of A: the word not yet known to be last, with its frame position and accept time
  bit          pend_a = 1'b0;
  logic [7:0]  pend_d = '0;
  int          pend_t = 0;
  int          cur_pos = 0;
  logic [15:0] efc_a = '0;
  logic [15:0] efc_b = '0;
  bit          hold_a = 1'b0;
  bit          hold_b = 1'b0;

  int n_acc_a, first_acc_a, last_acc_a, n_out_a, first_out_a, last_out_a;
  int n_flush_a, last_flush_a, n_acc_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_acc_a = 0; first_acc_a = 0; last_acc_a = 0;
    n_out_a = 0; first_out_a = 0; last_out_a = 0;
    n_flush_a = 0; last_flush_a = 0; n_acc_b = 0;
  endtask

  // One clock: observe and check at the falling edge, then advance past the rising edge.
  task automatic step();
    beat_t e;
    logic  acc_a, acc_b, exp_flush;
    int    pos;
    @(negedge clk);
    acc_a = in_valid & a_in_ready;
    acc_b = in_valid & b_in_ready;
    if (rst) begin
      chk("ready_a_in_reset", a_in_ready, 1'b0);
      chk("ready_b_in_reset", b_in_ready, 1'b0);
    end

    chk("frame_cnt_a", a_fc, efc_a);
    if (hold_a) chk("valid_held_a", a_tvalid, 1'b1);
    if (a_tvalid) begin
      chk("beat_avail_a", qa.size() > 0, 1'b1);
      if (qa.size() > 0) begin
        chk("beat_a", {a_tdata, a_tlast, a_tuser}, qa[0]);
        if (m_tready) begin
          e = qa.pop_front();
          if (e.last) efc_a++;
        end
      end
      if (m_tready) begin
        n_out_a++;
        if (n_out_a == 1) first_out_a = cyc;
        last_out_a = cyc;
      end
    end
    hold_a = a_tvalid & !m_tready & !rst;

    chk("frame_cnt_b", b_fc, efc_b);
    if (hold_b) chk("valid_held_b", b_tvalid, 1'b1);
    if (b_tvalid) begin
      chk("beat_avail_b", qb.size() > 0, 1'b1);
      if (qb.size() > 0) begin
        chk("beat_b", {b_tdata, b_tlast, b_tuser}, qb[0]);
        if (m_tready) begin
          void'(qb.pop_front());
          efc_b++;
        end
      end
    end
    hold_b = b_tvalid & !m_tready & !rst;

    exp_flush = 1'b0;
    if (rst) begin
      qa.delete(); qb.delete();
      pend_a = 1'b0; efc_a = '0; efc_b = '0;
    end else begin
      if (acc_a) begin
        n_acc_a++;
        if (n_acc_a == 1) first_acc_a = cyc;
        last_acc_a = cyc;
        if (pend_a) qa.push_back('{pend_d, 1'b0, cur_pos == 1});
        pos = pend_a ? cur_pos + 1 : 1;
        cur_pos = pos;
        if (pos == FL_A) begin
          qa.push_back('{in_data, 1'b1, pos == 1});
          pend_a = 1'b0;
        end else begin
          pend_a = 1'b1; pend_d = in_data; pend_t = cyc;
        end
      end else if (pend_a && (cyc - pend_t == TO_A)) begin
        exp_flush = 1'b1;
        qa.push_back('{pend_d, 1'b1, cur_pos == 1});
        pend_a = 1'b0;
      end
      if (acc_b) begin
        n_acc_b++;
        qb.push_back('{in_data, 1'b1, 1'b1});
      end
    end
    chk("flush_a", a_flush, exp_flush);
    chk("flush_b", b_flush, 1'b0);
    if (a_flush) begin
      n_flush_a++;
      last_flush_a = cyc;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 60 && (qa.size() > 0 || pend_a || qb.size() > 0); i++) step();
    step();
    step();
    chk("drain_a_left", qa.size() + int'(pend_a), 0);
    chk("drain_b_left", qb.size(), 0);
  endtask

  initial begin
    int pv, pr;
    logic [7:0] d;
    int nb;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; m_tready = 1'b1;
    clr_stats();
    step();
    step();
    rst = 1'b0;
    chk("rst_tvalid_a", a_tvalid, 1'b0);
    chk("rst_tdata_a", a_tdata, 8'h00);
    chk("rst_tlast_a", a_tlast, 1'b0);
    chk("rst_tuser_a", a_tuser, 1'b0);
    chk("rst_fc_a", a_fc, 16'h0);
    chk("rst_tvalid_b", b_tvalid, 1'b0);

    // 8 contiguous words: two full frames, 2-cycle fill, no bubbles
    clr_stats();
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
    drain();
    chk("t1_accepts", n_acc_a, 8);
    chk("t1_beats", n_out_a, 8);
    chk("t1_fill", first_out_a - first_acc_a, 2);
    chk("t1_span", last_out_a - first_out_a, 7);
    chk("t1_fc_a", a_fc, 16'd2);
    chk("t1_fc_b", b_fc, 16'd8);

    // Partial frame closed by timeout, next word starts a new frame
    clr_stats();
    send(8'hA0); send(8'hA1); send(8'hA2);
    idle(12);
    chk("t2_flushes", n_flush_a, 1);
    chk("t2_flush_at", last_flush_a - last_acc_a, TO_A);
    chk("t2_tlast_at", last_out_a - last_flush_a, 1);
    chk("t2_fc_a", a_fc, 16'd3);
    send(8'hB0);
    drain();

    // Accept lands exactly when the idle count would expire: accept wins
    clr_stats();
    send(8'h31);
    idle(TO_A - 1);
    send(8'h32);
    idle(12);
    chk("t3_gap", last_acc_a - first_acc_a, TO_A);
    chk("t3_flushes", n_flush_a, 1);
    chk("t3_flush_is_2nd", last_flush_a - last_acc_a, TO_A);
    chk("t3_beats", n_out_a, 2);

    // Backpressure from an empty pipeline: exactly two words absorbed
    clr_stats();
    m_tready = 1'b0; in_valid = 1'b1; d = 8'h40;
    for (int i = 0; i < 10; i++) begin
      nb = n_acc_a; in_data = d;
      step();
      if (n_acc_a > nb) d++;
    end
    chk("t4_accepts", n_acc_a, 2);
    chk("t4_in_ready", a_in_ready, 1'b0);
    chk("t4_tvalid", a_tvalid, 1'b1);
    chk("t4_tdata", a_tdata, 8'h40);
    m_tready = 1'b1;
    for (int i = 0; i < 20 && n_acc_a < 6; i++) begin
      nb = n_acc_a; in_data = d;
      step();
      if (n_acc_a > nb) d++;
    end
    drain();
    chk("t4_beats", n_out_a, 6);

    // Reset at frame position 3
    clr_stats();
    send(8'h51); send(8'h52); send(8'h53);
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("t5_tvalid_a", a_tvalid, 1'b0);
    chk("t5_tdata_a", a_tdata, 8'h00);
    chk("t5_tlast_a", a_tlast, 1'b0);
    chk("t5_tuser_a", a_tuser, 1'b0);
    chk("t5_fc_a", a_fc, 16'h0);
    chk("t5_tvalid_b", b_tvalid, 1'b0);
    clr_stats();
    for (int i = 0; i < 4; i++) send(8'h55 + 8'(i));
    drain();
    chk("t5_beats", n_out_a, 4);
    chk("t5_fc_a_after", a_fc, 16'd1);
    chk("t5_fc_b_after", b_fc, 16'd4);

    // Random traffic with phases of dense, sparse and stalled flow
    for (int i = 0; i < 480; i++) begin
      case ((i / 40) % 4)
        0:       begin pv = 95; pr = 100; end
        1:       begin pv = 60; pr = 70;  end
        2:       begin pv = 12; pr = 50;  end
        default: begin pv = 85; pr = 40;  end
      endcase
      in_valid = ($urandom_range(0, 99) < pv);
      m_tready = ($urandom_range(0, 99) < pr);
      in_data  = 8'($urandom);
      step();
    end
    drain();

    // frame_cnt wraparound, single-beat frames on B
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    clr_stats();
    in_valid = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_data = 8'(i);
      step();
    end
    drain();
    chk("wrap_acc_b", n_acc_b, 65535);
    chk("wrap_fc_b_max", b_fc, 16'hFFFF);
    chk("wrap_fc_a", a_fc, 16'd16384);
    send(8'h99);
    drain();
    chk("wrap_fc_b_zero", b_fc, 16'h0000);
    chk("wrap_fc_a_next", a_fc, 16'd16385);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
